// File: rtl/alt_mem_ddrx_mm_st_pipe_converter_if.sv
// Avalon-MM slave side plus controller command/write/read streaming channels.
// The converter takes the slave modport; the driving environment takes master.
interface alt_mem_ddrx_mm_st_pipe_converter_if #(
  parameter int AVL_SIZE_WIDTH = 3,
  parameter int AVL_ADDR_WIDTH = 25,
  parameter int AVL_DATA_WIDTH = 32,
  parameter int LOCAL_ID_WIDTH = 8
) ();
  localparam int BE_W = AVL_DATA_WIDTH / 8;

  logic                      avl_ready;
  logic                      avl_read_req;
  logic                      avl_write_req;
  logic [AVL_SIZE_WIDTH-1:0] avl_size;
  logic [AVL_ADDR_WIDTH-1:0] avl_addr;
  logic [AVL_DATA_WIDTH-1:0] avl_wdata;
  logic [BE_W-1:0]           avl_be;
  logic                      local_priority;
  logic                      local_autopch_req;
  logic                      local_multicast;
  logic                      avl_rdata_valid;
  logic [AVL_DATA_WIDTH-1:0] avl_rdata;
  logic                      local_rdata_error;

  logic                      itf_cmd_ready;
  logic                      itf_cmd_valid;
  logic                      itf_cmd;
  logic [AVL_ADDR_WIDTH-1:0] itf_cmd_address;
  logic [AVL_SIZE_WIDTH-1:0] itf_cmd_burstlen;
  logic [LOCAL_ID_WIDTH-1:0] itf_cmd_id;
  logic                      itf_cmd_priority;
  logic                      itf_cmd_autopercharge;
  logic                      itf_cmd_multicast;

  logic                      itf_wr_data_ready;
  logic                      itf_wr_data_valid;
  logic                      itf_wr_data_begin;
  logic                      itf_wr_data_last;
  logic [AVL_DATA_WIDTH-1:0] itf_wr_data;
  logic [BE_W-1:0]           itf_wr_data_byte_en;
  logic [LOCAL_ID_WIDTH-1:0] itf_wr_data_id;

  logic                      itf_rd_data_ready;
  logic                      itf_rd_data_valid;
  logic                      itf_rd_data_error;
  logic                      itf_rd_data_begin;
  logic                      itf_rd_data_last;
  logic [AVL_DATA_WIDTH-1:0] itf_rd_data;
  logic [LOCAL_ID_WIDTH-1:0] itf_rd_data_id;

  modport slave (
    output avl_ready, avl_rdata_valid, avl_rdata, local_rdata_error,
    input  avl_read_req, avl_write_req, avl_size, avl_addr, avl_wdata, avl_be,
    input  local_priority, local_autopch_req, local_multicast,
    input  itf_cmd_ready,
    output itf_cmd_valid, itf_cmd, itf_cmd_address, itf_cmd_burstlen, itf_cmd_id,
    output itf_cmd_priority, itf_cmd_autopercharge, itf_cmd_multicast,
    input  itf_wr_data_ready,
    output itf_wr_data_valid, itf_wr_data_begin, itf_wr_data_last,
    output itf_wr_data, itf_wr_data_byte_en, itf_wr_data_id,
    output itf_rd_data_ready,
    input  itf_rd_data_valid, itf_rd_data_error, itf_rd_data_begin, itf_rd_data_last,
    input  itf_rd_data, itf_rd_data_id
  );

  modport master (
    input  avl_ready, avl_rdata_valid, avl_rdata, local_rdata_error,
    output avl_read_req, avl_write_req, avl_size, avl_addr, avl_wdata, avl_be,
    output local_priority, local_autopch_req, local_multicast,
    output itf_cmd_ready,
    input  itf_cmd_valid, itf_cmd, itf_cmd_address, itf_cmd_burstlen, itf_cmd_id,
    input  itf_cmd_priority, itf_cmd_autopercharge, itf_cmd_multicast,
    output itf_wr_data_ready,
    input  itf_wr_data_valid, itf_wr_data_begin, itf_wr_data_last,
    input  itf_wr_data, itf_wr_data_byte_en, itf_wr_data_id,
    input  itf_rd_data_ready,
    output itf_rd_data_valid, itf_rd_data_error, itf_rd_data_begin, itf_rd_data_last,
    output itf_rd_data, itf_rd_data_id
  );
endinterface

// File: rtl/alt_mem_ddrx_mm_st_pipe_converter.sv
// Avalon-MM to streaming command/write-data converter with registered output
// stages, burst sequencing, command ID tagging and read-outstanding throttling.
module alt_mem_ddrx_mm_st_pipe_converter #(
  parameter int AVL_SIZE_WIDTH     = 3,
  parameter int AVL_ADDR_WIDTH     = 25,
  parameter int AVL_DATA_WIDTH     = 32,
  parameter int LOCAL_ID_WIDTH     = 8,
  parameter int MAX_RD_OUTSTANDING = 8
) (
  input  logic ctl_clk,
  input  logic ctl_reset_n,
  alt_mem_ddrx_mm_st_pipe_converter_if.slave bus
);
  localparam int BE_W     = AVL_DATA_WIDTH / 8;
  localparam int RD_CNT_W = $clog2(MAX_RD_OUTSTANDING + 1);

  typedef enum logic {IDLE, WR_DATA} state_t;

  state_t                    state_q, state_d;
  logic [LOCAL_ID_WIDTH-1:0] id_cnt_q, id_cnt_d;
  logic [RD_CNT_W-1:0]       rd_cnt_q, rd_cnt_d;
  logic [AVL_SIZE_WIDTH-1:0] burst_cnt_q, burst_cnt_d;

  logic                      cmd_valid_q, cmd_write_q;
  logic [AVL_ADDR_WIDTH-1:0] cmd_addr_q;
  logic [AVL_SIZE_WIDTH-1:0] cmd_len_q;
  logic [LOCAL_ID_WIDTH-1:0] cmd_id_q;
  logic                      cmd_pri_q, cmd_apch_q, cmd_mcast_q;

  logic                      wr_valid_q, wr_begin_q, wr_last_q;
  logic [AVL_DATA_WIDTH-1:0] wr_data_q;
  logic [BE_W-1:0]           wr_be_q;
  logic [LOCAL_ID_WIDTH-1:0] wr_id_q;

  logic                      cmd_free, wr_free, rd_room, rd_ret;
  logic                      avl_ready_c, wr_cmd_acc, rd_acc, beat_acc;
  logic [AVL_SIZE_WIDTH-1:0] burst_len;

  assign cmd_free  = ~cmd_valid_q | bus.itf_cmd_ready;
  assign wr_free   = ~wr_valid_q | bus.itf_wr_data_ready;
  assign rd_room   = rd_cnt_q < RD_CNT_W'(MAX_RD_OUTSTANDING);
  assign rd_ret    = bus.itf_rd_data_valid & bus.itf_rd_data_last;
  // Burstcount 0 is treated as a single beat
  assign burst_len = (bus.avl_size == '0) ? AVL_SIZE_WIDTH'(1) : bus.avl_size;

  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    avl_ready_c = 1'b0;
    wr_cmd_acc  = 1'b0;
    rd_acc      = 1'b0;
    beat_acc    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.avl_write_req) begin
          avl_ready_c = cmd_free & wr_free;
          wr_cmd_acc  = avl_ready_c;
          if (wr_cmd_acc && burst_len != AVL_SIZE_WIDTH'(1)) begin
            state_d     = WR_DATA;
            burst_cnt_d = burst_len - AVL_SIZE_WIDTH'(1);
          end
        end else if (bus.avl_read_req) begin
          avl_ready_c = cmd_free & rd_room;
          rd_acc      = avl_ready_c;
        end else begin
          avl_ready_c = cmd_free;
        end
      end
      WR_DATA: begin
        // Reads wait here; only data beats of the open burst are taken
        avl_ready_c = wr_free;
        beat_acc    = bus.avl_write_req & avl_ready_c;
        if (beat_acc) begin
          burst_cnt_d = burst_cnt_q - AVL_SIZE_WIDTH'(1);
          if (burst_cnt_q == AVL_SIZE_WIDTH'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    id_cnt_d = id_cnt_q + LOCAL_ID_WIDTH'(wr_cmd_acc | rd_acc);
    rd_cnt_d = rd_cnt_q;
    if (rd_acc && !rd_ret) rd_cnt_d = rd_cnt_q + RD_CNT_W'(1);
    else if (!rd_acc && rd_ret && rd_cnt_q != '0) rd_cnt_d = rd_cnt_q - RD_CNT_W'(1);
  end

  always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
    if (!ctl_reset_n) begin
      state_q     <= IDLE;
      id_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      id_cnt_q    <= id_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
    if (!ctl_reset_n) begin
      cmd_valid_q <= 1'b0;
      cmd_write_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_len_q   <= '0;
      cmd_id_q    <= '0;
      cmd_pri_q   <= 1'b0;
      cmd_apch_q  <= 1'b0;
      cmd_mcast_q <= 1'b0;
    end else if (wr_cmd_acc | rd_acc) begin
      cmd_valid_q <= 1'b1;
      cmd_write_q <= wr_cmd_acc;
      cmd_addr_q  <= bus.avl_addr;
      cmd_len_q   <= burst_len;
      cmd_id_q    <= id_cnt_q;
      cmd_pri_q   <= bus.local_priority;
      cmd_apch_q  <= bus.local_autopch_req;
      cmd_mcast_q <= bus.local_multicast;
    end else if (bus.itf_cmd_ready) begin
      cmd_valid_q <= 1'b0;
    end
  end

  // Beats after the first reuse wr_id_q, which still holds the burst's ID
  always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
    if (!ctl_reset_n) begin
      wr_valid_q <= 1'b0;
      wr_begin_q <= 1'b0;
      wr_last_q  <= 1'b0;
      wr_data_q  <= '0;
      wr_be_q    <= '0;
      wr_id_q    <= '0;
    end else if (wr_cmd_acc) begin
      wr_valid_q <= 1'b1;
      wr_begin_q <= 1'b1;
      wr_last_q  <= (burst_len == AVL_SIZE_WIDTH'(1));
      wr_data_q  <= bus.avl_wdata;
      wr_be_q    <= bus.avl_be;
      wr_id_q    <= id_cnt_q;
    end else if (beat_acc) begin
      wr_valid_q <= 1'b1;
      wr_begin_q <= 1'b0;
      wr_last_q  <= (burst_cnt_q == AVL_SIZE_WIDTH'(1));
      wr_data_q  <= bus.avl_wdata;
      wr_be_q    <= bus.avl_be;
    end else if (bus.itf_wr_data_ready) begin
      wr_valid_q <= 1'b0;
    end
  end

  assign bus.avl_ready             = avl_ready_c;
  assign bus.itf_cmd_valid         = cmd_valid_q;
  assign bus.itf_cmd               = cmd_write_q;
  assign bus.itf_cmd_address       = cmd_addr_q;
  assign bus.itf_cmd_burstlen      = cmd_len_q;
  assign bus.itf_cmd_id            = cmd_id_q;
  assign bus.itf_cmd_priority      = cmd_pri_q;
  assign bus.itf_cmd_autopercharge = cmd_apch_q;
  assign bus.itf_cmd_multicast     = cmd_mcast_q;
  assign bus.itf_wr_data_valid     = wr_valid_q;
  assign bus.itf_wr_data_begin     = wr_begin_q;
  assign bus.itf_wr_data_last      = wr_last_q;
  assign bus.itf_wr_data           = wr_data_q;
  assign bus.itf_wr_data_byte_en   = wr_be_q;
  assign bus.itf_wr_data_id        = wr_id_q;
  assign bus.itf_rd_data_ready     = 1'b1;
  assign bus.avl_rdata_valid       = bus.itf_rd_data_valid;
  assign bus.avl_rdata             = bus.itf_rd_data;
  assign bus.local_rdata_error     = bus.itf_rd_data_error;
endmodule

// File: tb/tb_alt_mem_ddrx_mm_st_pipe_converter.sv
// Directed bench: bursts, stalls, read throttling, ID wrap and mid-burst reset.
module tb_alt_mem_ddrx_mm_st_pipe_converter;
  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  logic [7:0] exp_id;

  always #5 clk = ~clk;

  alt_mem_ddrx_mm_st_pipe_converter_if bus ();

  alt_mem_ddrx_mm_st_pipe_converter dut (
    .ctl_clk     (clk),
    .ctl_reset_n (rst_n),
    .bus         (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.avl_read_req = 0; bus.avl_write_req = 0; bus.avl_size = 0;
    bus.avl_addr = 0; bus.avl_wdata = 0; bus.avl_be = 4'hF;
    bus.local_priority = 0; bus.local_autopch_req = 0; bus.local_multicast = 0;
    bus.itf_cmd_ready = 1; bus.itf_wr_data_ready = 1;
    bus.itf_rd_data_valid = 0; bus.itf_rd_data_error = 0; bus.itf_rd_data_begin = 0;
    bus.itf_rd_data_last = 0; bus.itf_rd_data = 0; bus.itf_rd_data_id = 0;
    step(); step();
    chk("rst_cmd_valid", 32'(bus.itf_cmd_valid), 0);
    chk("rst_wr_valid", 32'(bus.itf_wr_data_valid), 0);
    chk("rst_wr_begin", 32'(bus.itf_wr_data_begin), 0);
    chk("rst_wr_last", 32'(bus.itf_wr_data_last), 0);
    chk("rst_cmd_id", 32'(bus.itf_cmd_id), 0);
    chk("rd_ready_tied", 32'(bus.itf_rd_data_ready), 1);
    chk("rst_avl_ready", 32'(bus.avl_ready), 1);
    rst_n = 1'b1;
    step();

    // Write burst of 4 with sideband bits
    bus.avl_write_req = 1; bus.avl_size = 4; bus.avl_addr = 25'h123;
    bus.avl_wdata = 32'hA0; bus.avl_be = 4'h5;
    bus.local_priority = 1; bus.local_autopch_req = 1; bus.local_multicast = 0;
    #1 chk("b4_ready0", 32'(bus.avl_ready), 1);
    step();
    chk("b4_cmd_valid", 32'(bus.itf_cmd_valid), 1);
    chk("b4_cmd_write", 32'(bus.itf_cmd), 1);
    chk("b4_cmd_addr", 32'(bus.itf_cmd_address), 32'h123);
    chk("b4_cmd_len", 32'(bus.itf_cmd_burstlen), 4);
    chk("b4_cmd_id", 32'(bus.itf_cmd_id), 0);
    chk("b4_cmd_pri", 32'(bus.itf_cmd_priority), 1);
    chk("b4_cmd_apch", 32'(bus.itf_cmd_autopercharge), 1);
    chk("b4_cmd_mcast", 32'(bus.itf_cmd_multicast), 0);
    chk("b4_beat0_data", bus.itf_wr_data, 32'hA0);
    chk("b4_beat0_be", 32'(bus.itf_wr_data_byte_en), 5);
    chk("b4_beat0_begin", 32'(bus.itf_wr_data_begin), 1);
    chk("b4_beat0_last", 32'(bus.itf_wr_data_last), 0);
    chk("b4_beat0_id", 32'(bus.itf_wr_data_id), 0);
    bus.local_priority = 0; bus.local_autopch_req = 0;
    bus.avl_wdata = 32'hA1;
    #1 chk("b4_ready1", 32'(bus.avl_ready), 1);
    step();
    chk("b4_cmd_drained", 32'(bus.itf_cmd_valid), 0);
    chk("b4_beat1_data", bus.itf_wr_data, 32'hA1);
    chk("b4_beat1_begin", 32'(bus.itf_wr_data_begin), 0);
    chk("b4_beat1_last", 32'(bus.itf_wr_data_last), 0);
    bus.avl_wdata = 32'hA2;
    step();
    chk("b4_beat2_last", 32'(bus.itf_wr_data_last), 0);
    bus.avl_wdata = 32'hA3;
    step();
    chk("b4_beat3_data", bus.itf_wr_data, 32'hA3);
    chk("b4_beat3_last", 32'(bus.itf_wr_data_last), 1);
    chk("b4_beat3_begin", 32'(bus.itf_wr_data_begin), 0);
    chk("b4_beat3_id", 32'(bus.itf_wr_data_id), 0);
    bus.avl_write_req = 0;
    step();
    chk("b4_wr_drained", 32'(bus.itf_wr_data_valid), 0);

    // Command stage stall: held for 3 cycles, issued on the 4th
    bus.itf_cmd_ready = 0; bus.avl_read_req = 1; bus.avl_addr = 25'h55;
    #1 chk("st_ready_first", 32'(bus.avl_ready), 1);
    step();
    chk("st_cmd_read", 32'(bus.itf_cmd), 0);
    chk("st_cmd_id", 32'(bus.itf_cmd_id), 1);
    bus.avl_addr = 25'h66;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("st_ready_low", 32'(bus.avl_ready), 0);
      chk("st_addr_hold", 32'(bus.itf_cmd_address), 32'h55);
      chk("st_id_hold", 32'(bus.itf_cmd_id), 1);
      chk("st_valid_hold", 32'(bus.itf_cmd_valid), 1);
      step();
    end
    bus.itf_cmd_ready = 1;
    #1 chk("st_ready_release", 32'(bus.avl_ready), 1);
    step();
    chk("st_next_addr", 32'(bus.itf_cmd_address), 32'h66);
    chk("st_next_id", 32'(bus.itf_cmd_id), 2);

    // Six more reads reach 8 outstanding; the 9th is throttled
    for (int i = 0; i < 6; i++) begin
      #1 chk("rd_fill_ready", 32'(bus.avl_ready), 1);
      step();
    end
    chk("rd_fill_id", 32'(bus.itf_cmd_id), 8);
    #1 chk("rd_full_ready", 32'(bus.avl_ready), 0);
    bus.itf_rd_data_valid = 1; bus.itf_rd_data_last = 1;
    bus.itf_rd_data = 32'hDEADBEEF; bus.itf_rd_data_error = 1;
    #1;
    chk("rd_ret_ready", 32'(bus.avl_ready), 0);
    chk("rd_path_valid", 32'(bus.avl_rdata_valid), 1);
    chk("rd_path_data", bus.avl_rdata, 32'hDEADBEEF);
    chk("rd_path_err", 32'(bus.local_rdata_error), 1);
    step();
    chk("rd_blocked_no_cmd", 32'(bus.itf_cmd_valid), 0);
    bus.itf_rd_data_valid = 0; bus.itf_rd_data_last = 0; bus.itf_rd_data_error = 0;
    #1;
    chk("rd_room_ready", 32'(bus.avl_ready), 1);
    chk("rd_path_idle", 32'(bus.avl_rdata_valid), 0);
    step();
    chk("rd_9th_valid", 32'(bus.itf_cmd_valid), 1);
    chk("rd_9th_id", 32'(bus.itf_cmd_id), 9);
    #1 chk("rd_full_again", 32'(bus.avl_ready), 0);

    // Drain to 3, then accept and return in the same cycle
    bus.avl_read_req = 0;
    bus.itf_rd_data_valid = 1; bus.itf_rd_data_last = 1;
    for (int i = 0; i < 5; i++) step();
    bus.avl_read_req = 1;
    #1 chk("same_ready", 32'(bus.avl_ready), 1);
    step();
    chk("same_id", 32'(bus.itf_cmd_id), 10);
    bus.itf_rd_data_valid = 0; bus.itf_rd_data_last = 0;
    for (int i = 0; i < 5; i++) begin
      #1 chk("same_room", 32'(bus.avl_ready), 1);
      step();
    end
    #1 chk("same_full", 32'(bus.avl_ready), 0);
    chk("same_last_id", 32'(bus.itf_cmd_id), 15);

    // Write wins over a pending read; size 0 is a single beat
    bus.avl_write_req = 1; bus.avl_size = 0; bus.avl_wdata = 32'hC0;
    #1 chk("pri_ready", 32'(bus.avl_ready), 1);
    step();
    chk("pri_cmd_write", 32'(bus.itf_cmd), 1);
    chk("pri_len", 32'(bus.itf_cmd_burstlen), 1);
    chk("pri_begin", 32'(bus.itf_wr_data_begin), 1);
    chk("pri_last", 32'(bus.itf_wr_data_last), 1);
    chk("pri_id", 32'(bus.itf_cmd_id), 16);
    chk("pri_wr_id", 32'(bus.itf_wr_data_id), 16);
    bus.avl_write_req = 0;
    #1 chk("pri_read_pending", 32'(bus.avl_ready), 0);
    bus.avl_read_req = 0;
    bus.itf_rd_data_valid = 1; bus.itf_rd_data_last = 1;
    for (int i = 0; i < 8; i++) step();
    bus.itf_rd_data_valid = 0; bus.itf_rd_data_last = 0;

    // ID counter wraps 255 -> 0
    bus.avl_write_req = 1; bus.avl_size = 1;
    exp_id = 8'd17;
    for (int i = 0; i < 240; i++) begin
      step();
      chk("wrap_cmd_id", 32'(bus.itf_cmd_id), 32'(exp_id));
      chk("wrap_wr_id", 32'(bus.itf_wr_data_id), 32'(exp_id));
      exp_id = exp_id + 8'd1;
    end
    chk("wrap_end_id", 32'(bus.itf_cmd_id), 0);
    chk("wrap_end_begin", 32'(bus.itf_wr_data_begin), 1);
    chk("wrap_end_last", 32'(bus.itf_wr_data_last), 1);
    bus.avl_write_req = 0;
    step();

    // Write-data stage stall inside a burst of 2
    bus.avl_write_req = 1; bus.avl_size = 2; bus.avl_wdata = 32'hD0;
    step();
    chk("ws_id", 32'(bus.itf_wr_data_id), 1);
    bus.itf_wr_data_ready = 0; bus.avl_wdata = 32'hD1;
    #1 chk("ws_ready_low", 32'(bus.avl_ready), 0);
    step();
    chk("ws_data_hold", bus.itf_wr_data, 32'hD0);
    chk("ws_begin_hold", 32'(bus.itf_wr_data_begin), 1);
    bus.itf_wr_data_ready = 1;
    #1 chk("ws_ready_high", 32'(bus.avl_ready), 1);
    step();
    chk("ws_beat1_data", bus.itf_wr_data, 32'hD1);
    chk("ws_beat1_last", 32'(bus.itf_wr_data_last), 1);
    chk("ws_beat1_id", 32'(bus.itf_wr_data_id), 1);
    bus.avl_write_req = 0;
    step();

    // Reset in the middle of a burst of 4
    bus.avl_write_req = 1; bus.avl_size = 4; bus.avl_wdata = 32'hE0;
    step();
    bus.avl_wdata = 32'hE1;
    step();
    bus.avl_wdata = 32'hE2;
    step();
    #2 rst_n = 1'b0;
    bus.avl_write_req = 0;
    #1;
    chk("mr_cmd_valid", 32'(bus.itf_cmd_valid), 0);
    chk("mr_wr_valid", 32'(bus.itf_wr_data_valid), 0);
    chk("mr_wr_last", 32'(bus.itf_wr_data_last), 0);
    chk("mr_wr_data", bus.itf_wr_data, 0);
    step();
    rst_n = 1'b1;
    step(); step();
    chk("mr_no_beats", 32'(bus.itf_wr_data_valid), 0);
    bus.avl_read_req = 1; bus.avl_addr = 25'h77;
    #1 chk("mr_idle_ready", 32'(bus.avl_ready), 1);
    step();
    chk("mr_read_valid", 32'(bus.itf_cmd_valid), 1);
    chk("mr_read_cmd", 32'(bus.itf_cmd), 0);
    chk("mr_read_id", 32'(bus.itf_cmd_id), 0);
    bus.avl_read_req = 0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
